// File: rtl/pipe_scan_mux_pkg.sv
// Shared constants and helpers for the pipelined scan multiplexer.
package pipe_scan_mux_pkg;

  localparam int DEFAULT_W     = 8;
  localparam int DEFAULT_N_SEL = 4;

  // Number of registered 4:1 levels, which is also the pipeline latency.
  function automatic int levels_for(input int n_sel);
    return n_sel / 2;
  endfunction

  // Number of input channels addressed by an n_sel-bit select.
  function automatic int channels_for(input int n_sel);
    return 1 << n_sel;
  endfunction

  // LSB position of channel ch inside a flat bus of w-bit channels.
  function automatic int slice_lo(input int w, input int ch);
    return w * ch;
  endfunction

endpackage

// File: rtl/pipe_scan_mux_mux4_reg_stage.sv
// One registered 4:1 node of the mux tree. The sideband (valid, enable,
// wrap flag, full select) moves with the data so every level works on the
// select that belongs to its own sample.
module mux4_reg_stage #(
  parameter int W     = 8,
  parameter int N_SEL = 4,
  parameter int K     = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4*W-1:0]   d,
  input  logic             valid_d,
  input  logic             g_l_d,
  input  logic             wrap_d,
  input  logic [N_SEL-1:0] sel_d,
  output logic [W-1:0]     q,
  output logic             valid_q,
  output logic             g_l_q,
  output logic             wrap_q,
  output logic [N_SEL-1:0] sel_q
);

  logic [1:0] leg;

  assign leg = sel_d[2*K +: 2];

  // Register the selected leg and its sideband; payload holds across bubbles.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: data registers are reset too (not just valid) so Y reads 0 after reset.
    if (RST) begin
      q       <= '0;
      valid_q <= 1'b0;
      g_l_q   <= 1'b0;
      wrap_q  <= 1'b0;
      sel_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      valid_q <= valid_d;
      wrap_q  <= valid_d & wrap_d;
      if (valid_d) begin
        q     <= d[W*leg +: W];
        g_l_q <= g_l_d;
        sel_q <= sel_d;
      end
    end
  end

endmodule

// File: rtl/pipe_scan_mux.sv
// Pipelined W-bit, 2^N_SEL-channel mux built from registered 4:1 levels,
// with valid tagging, channel tagging and an auto-scan channel counter.
module pipe_scan_mux
  import pipe_scan_mux_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int N_SEL = DEFAULT_N_SEL
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         G_L,
  input  logic                         MODE,
  input  logic                         IN_VALID,
  input  logic [W*(1<<N_SEL)-1:0]      S,
  input  logic [N_SEL-1:0]             X,
  output logic [W-1:0]                 Y,
  output logic                         Y_VALID,
  output logic [N_SEL-1:0]             Y_CH,
  output logic                         SCAN_WRAP
);

  localparam int LEVELS = levels_for(N_SEL);
  localparam int CH     = channels_for(N_SEL);

  if (N_SEL < 2 || (N_SEL % 2) != 0) begin : g_bad_n_sel
    $error("pipe_scan_mux: N_SEL must be even and >= 2");
  end

  logic [N_SEL-1:0] cnt;
  logic [N_SEL-1:0] sel_in;
  logic             wrap_in;

  // Effective select and wrap tag for the sample presented this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    sel_in  = X;
    wrap_in = 1'b0;
    if (MODE) begin
      sel_in  = cnt;
      wrap_in = !G_L && (cnt == N_SEL'(CH - 1));
    end
  end

  // Scan counter advances only on enabled, valid scan samples; wraps naturally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (IN_VALID && MODE && !G_L) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Tree of registered 4:1 levels; level k has 4^(LEVELS-1-k) nodes.
  for (genvar k = 0; k < LEVELS; k++) begin : lvl
    localparam int NOUT = 1 << (2 * (LEVELS - 1 - k));

    logic [4*NOUT*W-1:0] din;
    logic                valid_d;
    logic                g_l_d;
    logic                wrap_d;
    logic [N_SEL-1:0]    sel_d;

    logic [NOUT*W-1:0]   q;
    logic                valid;
    logic                g_l;
    logic                wrap;
    logic [N_SEL-1:0]    sel;

    if (k == 0) begin : src_in
      assign din     = S;
      assign valid_d = IN_VALID;
      assign g_l_d   = G_L;
      assign wrap_d  = wrap_in;
      assign sel_d   = sel_in;
    end else begin : src_prev
      assign din     = lvl[k-1].q;
      assign valid_d = lvl[k-1].valid;
      assign g_l_d   = lvl[k-1].g_l;
      assign wrap_d  = lvl[k-1].wrap;
      assign sel_d   = lvl[k-1].sel;
    end

    for (genvar j = 0; j < NOUT; j++) begin : node
      if (j == 0) begin : head
        // The head node's sideband copy is the one carried to the next level.
        mux4_reg_stage #(.W(W), .N_SEL(N_SEL), .K(k)) u_stage (
          .CLK     (CLK),
          .RST     (RST),
          .d       (din[slice_lo(W, 4*j) +: 4*W]),
          .valid_d (valid_d),
          .g_l_d   (g_l_d),
          .wrap_d  (wrap_d),
          .sel_d   (sel_d),
          .q       (q[slice_lo(W, j) +: W]),
          .valid_q (valid),
          .g_l_q   (g_l),
          .wrap_q  (wrap),
          .sel_q   (sel)
        );
      end else begin : body
        // Sideband copies in the other nodes are identical to the head's.
        logic             valid_unused;
        logic             g_l_unused;
        logic             wrap_unused;
        logic [N_SEL-1:0] sel_unused;

        mux4_reg_stage #(.W(W), .N_SEL(N_SEL), .K(k)) u_stage (
          .CLK     (CLK),
          .RST     (RST),
          .d       (din[slice_lo(W, 4*j) +: 4*W]),
          .valid_d (valid_d),
          .g_l_d   (g_l_d),
          .wrap_d  (wrap_d),
          .sel_d   (sel_d),
          .q       (q[slice_lo(W, j) +: W]),
          .valid_q (valid_unused),
          .g_l_q   (g_l_unused),
          .wrap_q  (wrap_unused),
          .sel_q   (sel_unused)
        );
      end
    end
  end

  // Outputs come straight from the last level's registers; a disabled
  // sample reads as 0 and that value is held through following bubbles.
  assign Y         = lvl[LEVELS-1].g_l ? '0 : lvl[LEVELS-1].q;
  assign Y_VALID   = lvl[LEVELS-1].valid;
  assign Y_CH      = lvl[LEVELS-1].sel;
  assign SCAN_WRAP = lvl[LEVELS-1].wrap;

endmodule

// File: tb/tb_pipe_scan_mux.sv
// Directed self-checking bench for pipe_scan_mux at default parameters.
module tb_pipe_scan_mux;

  localparam int W      = 8;
  localparam int N_SEL  = 4;
  localparam int CH     = 16;
  localparam int LEVELS = 2;

  logic               clk;
  logic               rst;
  logic               g_l;
  logic               mode;
  logic               in_valid;
  logic [W*CH-1:0]    s;
  logic [N_SEL-1:0]   x;
  logic [W-1:0]       y;
  logic               y_valid;
  logic [N_SEL-1:0]   y_ch;
  logic               scan_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit         valid;
    logic [7:0] y;
    logic [3:0] ch;
    bit         wrap;
  } exp_t;

  exp_t       pend[$];
  logic [7:0] last_y;

  pipe_scan_mux #(.W(W), .N_SEL(N_SEL)) dut (
    .CLK       (clk),
    .RST       (rst),
    .G_L       (g_l),
    .MODE      (mode),
    .IN_VALID  (in_valid),
    .S         (s),
    .X         (x),
    .Y         (y),
    .Y_VALID   (y_valid),
    .Y_CH      (y_ch),
    .SCAN_WRAP (scan_wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one sample, advance one clock, and check the sample issued
  // LEVELS cycles earlier against its hand-given expectation.
  task automatic issue(input string tag, input bit m, input bit v, input bit gl,
                       input logic [3:0] xs, input logic [3:0] ech,
                       input logic [7:0] ey, input bit ewrap);
    exp_t e;
    mode     = m;
    in_valid = v;
    g_l      = gl;
    x        = xs;
    e.valid  = v;
    e.ch     = ech;
    e.wrap   = v & ewrap;
    if (v) begin
      e.y    = gl ? 8'h00 : ey;
      last_y = e.y;
    end else begin
      e.y    = last_y;
    end
    pend.push_back(e);
    @(posedge clk);
    #1;
    if (pend.size() == LEVELS) begin
      e = pend.pop_front();
      check({tag, ".valid"}, 32'(y_valid),   32'(e.valid));
      check({tag, ".y"},     32'(y),         32'(e.y));
      check({tag, ".wrap"},  32'(scan_wrap), 32'(e.wrap));
      if (e.valid) check({tag, ".ch"}, 32'(y_ch), 32'(e.ch));
    end
  endtask

  task automatic direct(input string tag, input logic [3:0] xs);
    issue(tag, 1'b0, 1'b1, 1'b0, xs, xs, 8'(xs) * 8'h11, 1'b0);
  endtask

  task automatic scan(input string tag, input logic [3:0] ech);
    issue(tag, 1'b1, 1'b1, 1'b0, 4'h0, ech, 8'(ech) * 8'h11, ech == 4'hF);
  endtask

  task automatic bubble(input string tag, input bit m);
    issue(tag, m, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    g_l      = 1'b0;
    mode     = 1'b0;
    in_valid = 1'b0;
    x        = '0;
    last_y   = 8'h00;
    for (int i = 0; i < CH; i++) s[W*i +: W] = 8'(i * 17);

    // Reset state
    #12;
    check("rst.y",     32'(y),         32'h0);
    check("rst.valid", 32'(y_valid),   32'h0);
    check("rst.ch",    32'(y_ch),      32'h0);
    check("rst.wrap",  32'(scan_wrap), 32'h0);
    check("rst.cnt",   32'(dut.cnt),   32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Direct selects, single and back-to-back, then a drain with held Y
    direct("d5", 4'd5);
    direct("d0", 4'd0);
    direct("d15", 4'd15);
    direct("d10", 4'd10);
    bubble("drain0", 1'b0);
    bubble("drain1", 1'b0);

    // Scan from counter 0 through a wrap
    for (int i = 0; i < 18; i++) scan($sformatf("scan%0d", i), 4'(i % 16));

    // Scan to channel 6, three bubbles, one direct sample, then resume at 7
    for (int i = 2; i <= 6; i++) scan($sformatf("scanb%0d", i), 4'(i));
    bubble("gap0", 1'b1);
    bubble("gap1", 1'b1);
    bubble("gap2", 1'b1);
    direct("ins2", 4'd2);
    scan("resume7", 4'd7);
    scan("resume8", 4'd8);

    // Disabled samples: Y=0, tag kept, counter frozen
    issue("gl_d9", 1'b0, 1'b1, 1'b1, 4'd9, 4'd9, 8'h99, 1'b0);
    bubble("gl_hold", 1'b0);
    issue("gl_scan", 1'b1, 1'b1, 1'b1, 4'd0, 4'd9, 8'h99, 1'b0);
    check("gl.cnt", 32'(dut.cnt), 32'd9);
    scan("after_gl9", 4'd9);
    scan("pre_rst10", 4'd10);

    // Asynchronous reset mid-cycle with samples in flight
    mode     = 1'b1;
    in_valid = 1'b1;
    #3;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mrst.valid", 32'(y_valid),   32'h0);
    check("mrst.y",     32'(y),         32'h0);
    check("mrst.ch",    32'(y_ch),      32'h0);
    check("mrst.wrap",  32'(scan_wrap), 32'h0);
    check("mrst.cnt",   32'(dut.cnt),   32'h0);
    pend.delete();
    last_y = 8'h00;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst.valid", 32'(y_valid), 32'h0);

    // First new sample needs the full LEVELS cycles
    direct("r3", 4'd3);
    check("post_rst.lat1", 32'(y_valid), 32'h0);
    scan("r_scan0", 4'd0);
    bubble("r_drain0", 1'b0);
    bubble("r_drain1", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_scan_mux.md
Name: pipe_scan_mux

Overview:
- Parametrised, pipelined W-bit, 2^N_SEL-channel multiplexer built as a tree of registered 4:1 stages.
- Successor to the combinational 16:1 single-bit mux; adds data width, channel-count generalisation, valid tagging and an auto-scan mode (internal channel counter).
- Sits between the multi-channel sample bus and a single downstream consumer (display/serial path) that needs a steady, tagged channel stream.

Parameters:
- W, 8, data width of each channel and of Y.
- N_SEL, 4, select width; channel count = 2^N_SEL; must be even and >= 2 (elaboration error otherwise).
- LEVELS, N_SEL/2, derived (localparam), number of 4:1 tree levels = pipeline latency.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- G_L  input  1  active-low enable, sampled with the input sample.
- MODE  input  1  0 = direct select from X, 1 = scan (internal counter selects).
- IN_VALID  input  1  a sample is presented this cycle.
- S  input  W*2^N_SEL  channel data; channel i occupies S[W*i+W-1 : W*i].
- X  input  N_SEL  channel select in direct mode; ignored in scan mode.
- Y  output  W  selected data.
- Y_VALID  output  1  Y/Y_CH hold a valid sample this cycle.
- Y_CH  output  N_SEL  channel index that produced Y.
- SCAN_WRAP  output  1  accompanies the output sample of channel 2^N_SEL-1 taken in scan mode.

Behaviour:
- Reset (async, any time): all pipeline registers, Y=0, Y_VALID=0, Y_CH=0, SCAN_WRAP=0, scan counter=0. In-flight samples are discarded; no output valid until a new sample traverses the full pipe.
- Effective select SEL = MODE ? cnt : X, evaluated in the input cycle.
- Level k (k=0..LEVELS-1) performs 4:1 selects using SEL[2k+1:2k] and registers the result. Upper select bits, G_L, valid, SEL and wrap flag travel alongside the data in the same pipeline registers, so each level uses the select belonging to its own sample.
- Latency: a sample presented at rising edge t appears on Y/Y_VALID/Y_CH after edge t+LEVELS (2 cycles at defaults). Throughput 1 sample/cycle; no back-pressure.
- IN_VALID=0: a bubble propagates (Y_VALID=0 for that slot); Y holds its last value during bubbles.
- G_L=1 on a valid sample: sample still propagates with Y_VALID=1 and its Y_CH, but Y=0 (disabled-mux output is 0, matching the 74x153 convention).
- Scan counter cnt (N_SEL bits): increments when IN_VALID=1 && MODE=1 && G_L=0; otherwise holds. Wraps 2^N_SEL-1 -> 0. A valid scan sample taken with cnt=2^N_SEL-1 sets its wrap flag; SCAN_WRAP is 1 only in that sample's output cycle.
- Mode switching: takes effect on the next sample; cnt is neither cleared nor advanced by direct-mode samples, so scan resumes where it stopped. Samples already in the pipe are unaffected.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package: localparam helper for LEVELS, channel-count constant, and the slice-index function for channel i in S.
- One sub-module: mux4_reg_stage (W-bit registered 4:1 with async-high reset, carries valid/G_L/tag sideband). Instantiate via a generate loop: 4^(LEVELS-1-k) instances at level k.
- Counter and wrap logic live in the top level.

Test Plan:
- Defaults, S channel i = i*0x11; MODE=0, X=5, IN_VALID=1 at edge t -> at edge t+2: Y=0x55, Y_CH=5, Y_VALID=1, SCAN_WRAP=0.
- Back-to-back direct X=0,15,10 on consecutive edges -> outputs 0x00, 0xFF, 0xAA with Y_CH 0, 15, 10 on three consecutive cycles.
- MODE=1, IN_VALID=1 for 18 cycles from reset -> Y_CH sequence 0..15,0,1; Y = Y_CH*0x11; SCAN_WRAP=1 only alongside Y_CH=15.
- Scan with IN_VALID low for 3 cycles after channel 6, and a direct-mode sample X=2 inserted -> Y_VALID gaps of 3, direct sample tagged 2, scan resumes at channel 7.
- G_L=1 on a valid sample with X=9 -> Y=0x00, Y_CH=9, Y_VALID=1; scan counter does not advance while G_L=1.
- RST asserted mid-cycle with two samples in flight -> Y_VALID, Y, Y_CH, cnt go to 0 immediately (before the next clock edge); after release, first output appears LEVELS cycles after the first new sample.
